ysyx_22050133_stall_ctrl: RTL and testbench

Pipeline stall and issue controller for the five-stage core. It merges the decode-stage load-use hazard with the sequencing of the shared multi-cycle multiply/divide unit (MDU). While an MDU instruction sits in EX, it issues the operation, holds IF/ID/EX and bubbles MEM until the result returns. It drives the decode-stage `block` input and the hold/bubble enables of every pipeline register.

---
 rtl/ysyx_22050133_stall_ctrl_if.sv | 42 ++++
 rtl/ysyx_22050133_stall_ctrl.sv | 130 +++++++++++++
 tb/tb_ysyx_22050133_stall_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050133_stall_ctrl_if.sv
// Bundle of the pipeline-control and MDU handshake signals around the
// stall controller. The controller side uses the master modport; the
// pipeline/MDU environment uses the slave modport.
interface ysyx_22050133_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    // decode / EX / MEM side inputs
    logic             has_hazard;
    logic             ex_valid;
    logic             ex_mdu_req;
    logic             flush;
    // MDU handshake
    logic             mdu_in_ready;
    logic             mdu_out_valid;
    logic             mdu_in_valid;
    logic             mdu_flush;
    // pipeline register controls
    logic             stall_if;
    logic             stall_id;
    logic             bubble_ex;
    logic             bubble_mem;
    logic             mdu_take;
    // status
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  has_hazard, ex_valid, ex_mdu_req, flush,
        input  mdu_in_ready, mdu_out_valid,
        output mdu_in_valid, mdu_flush,
        output stall_if, stall_id, bubble_ex, bubble_mem, mdu_take,
        output busy, stall_cnt
    );

    modport slave (
        output has_hazard, ex_valid, ex_mdu_req, flush,
        output mdu_in_ready, mdu_out_valid,
        input  mdu_in_valid, mdu_flush,
        input  stall_if, stall_id, bubble_ex, bubble_mem, mdu_take,
        input  busy, stall_cnt
    );
endinterface

// File: rtl/ysyx_22050133_stall_ctrl.sv
// Pipeline stall and issue controller: merges the decode load-use hazard
// with sequencing of the shared multi-cycle MDU. While an MDU instruction
// sits in EX it issues the operation, holds IF/ID/EX and bubbles MEM until
// the result comes back. A redirect (flush) overrides every stall/issue.
module ysyx_22050133_stall_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                               clk,
    input  logic                               rst,    // async, active-low
    ysyx_22050133_stall_ctrl_if.master         bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no MDU operation outstanding
        ISSUE = 2'd1,   // request raised, MDU not yet ready
        WAIT  = 2'd2    // accepted, waiting for the result pulse
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    logic req;
    logic mdu_stall;
    logic in_valid;
    logic abort;
    logic take;

    // A flushed EX instruction never counts as a request.
    assign req = bus.ex_valid & bus.ex_mdu_req & ~bus.flush;

    // State register; the MDU shares this reset so no abort is needed here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: flush wins, otherwise follow the issue/accept/result handshake.
    always_comb begin
        state_next = state_reg;
        if (bus.flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        state_next = bus.mdu_in_ready ? WAIT : ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mdu_in_ready) begin
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mdu_out_valid) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs: issue/abort/take per state, then the pipeline stall/bubble map.
    always_comb begin
        in_valid  = 1'b0;
        abort     = 1'b0;
        take      = 1'b0;
        mdu_stall = 1'b0;
        case (state_reg)
            IDLE: begin
                // issue in the same cycle the instruction shows up in EX
                in_valid  = req;
                mdu_stall = req;
            end
            ISSUE: begin
                in_valid  = ~bus.flush;
                abort     = bus.flush;
                mdu_stall = ~bus.flush;
            end
            WAIT: begin
                // the result cycle itself is unstalled: EX/MEM captures it
                take      = ~bus.flush & bus.mdu_out_valid;
                abort     = bus.flush;
                mdu_stall = ~bus.flush & ~bus.mdu_out_valid;
            end
            default: begin
                in_valid  = 1'b0;
                abort     = 1'b0;
                take      = 1'b0;
                mdu_stall = 1'b0;
            end
        endcase

        bus.mdu_in_valid = in_valid;
        bus.mdu_flush    = abort;
        bus.mdu_take     = take;
        bus.stall_id     = mdu_stall;
        bus.bubble_mem   = mdu_stall;
        bus.stall_if     = ~bus.flush & (mdu_stall | bus.has_hazard);
        // a held ID/EX register must keep its instruction, so never bubble it
        bus.bubble_ex    = ~bus.flush & bus.has_hazard & ~mdu_stall;
    end

    // Saturating count of MDU stall cycles.
    always_comb begin
        cnt_next = cnt_reg;
        if (mdu_stall && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Performance counter register; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.stall_cnt = cnt_reg;

endmodule

// File: tb/tb_ysyx_22050133_stall_ctrl.sv
// Scoreboard bench for the stall controller. The driver applies one cycle
// of inputs, computes the expected outputs from a small transaction-level
// model (pending / in-flight flags plus an integer counter) and queues
// them; a negedge monitor pops and compares against the DUT.
module tb_ysyx_22050133_stall_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    ysyx_22050133_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    ysyx_22050133_stall_ctrl #(.CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int in_valid;
        int mflush;
        int sif;
        int sid;
        int bex;
        int bmem;
        int take;
        int busy;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mon_bad;

    // reference model state
    bit m_pend;   // request raised, not yet accepted
    bit m_infl;   // accepted, result not yet returned
    int m_cnt;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_field(input string nm, input int act, input int exp);
        if (act != exp) begin
            mon_bad = 1'b1;
            $display("FAIL cyc%0d %s: got %0d, expected %0d", cyc, nm, act, exp);
        end
    endtask

    // one cycle of stimulus plus its expected response
    task automatic drive(input bit hz, input bit ev, input bit mr,
                         input bit fl, input bit rdy, input bit ov);
        exp_t e;
        bit   rq;
        bit   idle;
        bit   stall;
        @(posedge clk);
        #1;
        bus.has_hazard    = hz;
        bus.ex_valid      = ev;
        bus.ex_mdu_req    = mr;
        bus.flush         = fl;
        bus.mdu_in_ready  = rdy;
        bus.mdu_out_valid = ov;

        rq    = ev && mr && !fl;
        idle  = !m_pend && !m_infl;
        stall = !fl && ((idle && rq) || m_pend || (m_infl && !ov));

        e.in_valid = int'(!fl && ((idle && rq) || m_pend));
        e.mflush   = int'(fl && (m_pend || m_infl));
        e.take     = int'(!fl && m_infl && ov);
        e.sid      = int'(stall);
        e.bmem     = int'(stall);
        e.sif      = int'(!fl && (stall || hz));
        e.bex      = int'(!fl && hz && !stall);
        e.busy     = int'(!idle);
        e.cnt      = m_cnt;
        q.push_back(e);

        if (stall && m_cnt < CNT_MAX) m_cnt++;
        if (fl) begin
            m_pend = 1'b0;
            m_infl = 1'b0;
        end else if (idle && rq) begin
            if (rdy) m_infl = 1'b1;
            else     m_pend = 1'b1;
        end else if (m_pend && rdy) begin
            m_pend = 1'b0;
            m_infl = 1'b1;
        end else if (m_infl && ov) begin
            m_infl = 1'b0;
        end
    endtask

    task automatic zero_inputs();
        bus.has_hazard    = 1'b0;
        bus.ex_valid      = 1'b0;
        bus.ex_mdu_req    = 1'b0;
        bus.flush         = 1'b0;
        bus.mdu_in_ready  = 1'b0;
        bus.mdu_out_valid = 1'b0;
    endtask

    // async reset applied mid-cycle, checked before any clock edge
    task automatic apply_reset();
        @(negedge clk);
        #1;
        zero_inputs();
        rst = 1'b0;
        #1;
        check("rst_busy",      int'(bus.busy),         0);
        check("rst_stall_cnt", int'(bus.stall_cnt),    0);
        check("rst_in_valid",  int'(bus.mdu_in_valid), 0);
        check("rst_stall_if",  int'(bus.stall_if),     0);
        check("rst_bubble_ex", int'(bus.bubble_ex),    0);
        q.delete();
        m_pend = 1'b0;
        m_infl = 1'b0;
        m_cnt  = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // monitor: compare every queued expectation on the falling edge
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            mon_bad = 1'b0;
            n_checks++;
            cmp_field("mdu_in_valid", int'(bus.mdu_in_valid), e.in_valid);
            cmp_field("mdu_flush",    int'(bus.mdu_flush),    e.mflush);
            cmp_field("stall_if",     int'(bus.stall_if),     e.sif);
            cmp_field("stall_id",     int'(bus.stall_id),     e.sid);
            cmp_field("bubble_ex",    int'(bus.bubble_ex),    e.bex);
            cmp_field("bubble_mem",   int'(bus.bubble_mem),   e.bmem);
            cmp_field("mdu_take",     int'(bus.mdu_take),     e.take);
            cmp_field("busy",         int'(bus.busy),         e.busy);
            cmp_field("stall_cnt",    int'(bus.stall_cnt),    e.cnt);
            if (mon_bad) n_fail++;
            if (cyc < 80) begin
                $display("cyc %0d: iv=%0d fl=%0d sif=%0d sid=%0d bex=%0d bmem=%0d take=%0d busy=%0d cnt=%0d",
                         cyc, bus.mdu_in_valid, bus.mdu_flush, bus.stall_if, bus.stall_id,
                         bus.bubble_ex, bus.bubble_mem, bus.mdu_take, bus.busy, bus.stall_cnt);
            end
            cyc++;
        end
    end

    initial begin
        zero_inputs();
        m_pend = 1'b0;
        m_infl = 1'b0;
        m_cnt  = 0;
        rst    = 1'b0;
        #12;
        check("por_busy",      int'(bus.busy),      0);
        check("por_stall_cnt", int'(bus.stall_cnt), 0);
        check("por_stall_id",  int'(bus.stall_id),  0);
        rst = 1'b1;

        // load-use only
        $display("scenario: load-use");
        drive(1, 0, 0, 0, 0, 0);
        #1;
        check("lu_stall_if",  int'(bus.stall_if),  1);
        check("lu_bubble_ex", int'(bus.bubble_ex), 1);
        check("lu_stall_id",  int'(bus.stall_id),  0);
        drive(0, 0, 0, 0, 0, 0);
        check("lu_cnt", int'(bus.stall_cnt), 0);

        // MUL, ready high, latency 3
        $display("scenario: mul latency 3");
        apply_reset();
        drive(0, 1, 1, 0, 1, 0);
        #1;
        check("mul_issue", int'(bus.mdu_in_valid), 1);
        drive(0, 1, 1, 0, 1, 0);
        #1;
        check("mul_no_reissue", int'(bus.mdu_in_valid), 0);
        drive(0, 1, 1, 0, 1, 0);
        drive(0, 1, 1, 0, 1, 1);
        #1;
        check("mul_take", int'(bus.mdu_take), 1);
        check("mul_stall_off", int'(bus.stall_id), 0);
        drive(0, 0, 0, 0, 0, 0);
        check("mul_cnt", int'(bus.stall_cnt), 3);

        // DIV, ready low 2 cycles, latency 4
        $display("scenario: div ready-low 2, latency 4");
        apply_reset();
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        #1;
        check("div_issue_hold", int'(bus.mdu_in_valid), 1);
        drive(0, 1, 1, 0, 1, 0);
        drive(0, 1, 1, 0, 1, 0);
        drive(0, 1, 1, 0, 1, 0);
        drive(0, 1, 1, 0, 1, 0);
        drive(0, 1, 1, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0);
        check("div_cnt", int'(bus.stall_cnt), 6);

        // flush during WAIT
        $display("scenario: flush in wait");
        apply_reset();
        drive(0, 1, 1, 0, 1, 0);
        drive(0, 1, 1, 0, 1, 0);
        drive(1, 1, 1, 1, 1, 0);
        #1;
        check("fl_mdu_flush", int'(bus.mdu_flush), 1);
        check("fl_stall_if",  int'(bus.stall_if),  0);
        check("fl_bubble_ex", int'(bus.bubble_ex), 0);
        drive(0, 0, 0, 0, 1, 1);
        #1;
        check("fl_stray_take", int'(bus.mdu_take), 0);
        check("fl_busy",       int'(bus.busy),     0);
        check("fl_cnt",        int'(bus.stall_cnt), 2);

        // back-to-back MUL, latency 2
        $display("scenario: back-to-back mul");
        apply_reset();
        drive(0, 1, 1, 0, 1, 0);
        drive(0, 1, 1, 0, 1, 0);
        drive(0, 1, 1, 0, 1, 1);
        drive(0, 1, 1, 0, 1, 0);
        #1;
        check("b2b_issue_next", int'(bus.mdu_in_valid), 1);
        drive(0, 1, 1, 0, 1, 0);
        drive(0, 1, 1, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0);
        check("b2b_cnt", int'(bus.stall_cnt), 4);

        // async reset in WAIT, then saturation
        $display("scenario: async reset in wait");
        apply_reset();
        drive(0, 1, 1, 0, 1, 0);
        drive(0, 1, 1, 0, 1, 0);
        #1;
        check("pre_rst_busy", int'(bus.busy), 1);
        apply_reset();
        $display("scenario: saturation");
        for (int i = 0; i < 20; i++) drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0);
        check("sat_cnt", int'(bus.stall_cnt), CNT_MAX);

        // randomized traffic
        $display("scenario: random");
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom % 4) == 0, ($urandom % 4) != 0, ($urandom % 2) == 0,
                  ($urandom % 10) == 0, ($urandom % 3) != 0, ($urandom % 3) == 0);
            if (i == 700) apply_reset();
        end

        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
